serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 144 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// Captures two WIDTH-bit operands on start, runs one full-adder stage per
// clock (LSB first) with the carry held in a flop, then presents sum and
// carry_out together with a one-cycle done strobe.
// Optional feature macro: SERIAL_ADD_SUB_EN (adds the sub port; a - b).
//
// Handshake: start is sampled only while idle (busy=0, done=0); an accepted
// start raises busy on the next cycle. busy stays high for exactly WIDTH
// cycles, then done pulses for one cycle with sum/carry_out valid, and the
// block is idle again on the following cycle. start while busy or done is
// dropped, not queued. sum/carry_out hold their value until the next done.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] s_msb;
    logic             carry;
    logic             carry_init;
    logic             b_eff;
    logic             s;
    logic             c;
    logic             last;

`ifdef SERIAL_ADD_SUB_EN
    logic sub_q;
    assign b_eff      = sub_q ? ~b_sr[0] : b_sr[0];
    assign carry_init = sub;
`else
    assign b_eff      = b_sr[0];
    assign carry_init = 1'b0;
`endif

    // Final RUN cycle is the one where the counter holds WIDTH-1.
    assign last      = (cnt == CW'(WIDTH - 1));
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and status outputs; busy and done are decoded from distinct states.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One-bit full adder; its sum bit enters the result register at the MSB.
    always_comb begin
        s       = a_sr[0] ^ b_eff ^ carry;
        c       = (a_sr[0] & b_eff) | (a_sr[0] & carry) | (b_eff & carry);
        s_msb   = '0;
        s_msb[WIDTH-1] = s;
        res_nxt = (res >> 1) | s_msb;
    end

    // Operand capture, serial shifting and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr      <= '0;
            b_sr      <= '0;
            res       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        res   <= '0;
                        carry <= carry_init;
                        cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
                        sub_q <= sub;
`endif
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    res   <= res_nxt;
                    carry <= c;
                    cnt   <= cnt + CW'(1);
                    // Outputs only change once the full word is done.
                    if (last) begin
                        sum       <= res_nxt;
                        carry_out <= c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic [1:0]   dbg_state;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: one start pulse, operands scrambled right after capture.
    // lat = edges after the start edge until done is seen (-1 if never).
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                          output int lat, output int busy_n, output int overlap,
                          output logic [W-1:0] s_o, output logic c_o);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub = sv;
`endif
        @(negedge clk);
        start = 1'b0;
        a = ~av; b = ~bv;
`ifdef SERIAL_ADD_SUB_EN
        sub = ~sv;
`endif
        lat = -1; busy_n = 0; overlap = 0; s_o = 'x; c_o = 1'bx;
        for (int k = 0; k < 40; k++) begin
            if (busy && done) overlap++;
            if (busy) busy_n++;
            if (done) begin
                lat = k; s_o = sum; c_o = carry_out;
                break;
            end
            @(negedge clk);
        end
        if (sv === 1'bx) lat = lat; // sv only meaningful with subtract enabled
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        #12;
        chk_cnt++; if ({busy, done, sum, carry_out} !== '0) $display("FAIL reset_outputs got busy=%b done=%b sum=%0d c=%b want all 0", busy, done, sum, carry_out); else pass_cnt++;
        chk_cnt++; if (dbg_state !== 2'd0) $display("FAIL reset_state got %0d want 0", dbg_state); else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [W-1:0] es, input logic ec, input string nm);
        int lat, bn, ov; logic [W-1:0] s_o; logic c_o;
        run_op(av, bv, 1'b0, lat, bn, ov, s_o, c_o);
        chk_cnt++; if (lat !== W) $display("FAIL %s_latency got %0d want %0d", nm, lat, W); else pass_cnt++;
        chk_cnt++; if (bn !== W) $display("FAIL %s_busy_cycles got %0d want %0d", nm, bn, W); else pass_cnt++;
        chk_cnt++; if (ov !== 0) $display("FAIL %s_busy_done_overlap got %0d want 0", nm, ov); else pass_cnt++;
        chk_cnt++; if (s_o !== es) $display("FAIL %s_sum got %0d want %0d", nm, s_o, es); else pass_cnt++;
        chk_cnt++; if (c_o !== ec) $display("FAIL %s_carry got %b want %b", nm, c_o, ec); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if ({busy, done} !== 2'b00 || dbg_state !== 2'd0) $display("FAIL %s_idle_after got busy=%b done=%b st=%0d want 0 0 0", nm, busy, done, dbg_state); else pass_cnt++;
        chk_cnt++; if (sum !== es) $display("FAIL %s_sum_held got %0d want %0d", nm, sum, es); else pass_cnt++;
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [W-1:0] es, input logic ec, input string nm);
        int lat, bn, ov; logic [W-1:0] s_o; logic c_o;
        run_op(av, bv, 1'b1, lat, bn, ov, s_o, c_o);
        chk_cnt++; if (s_o !== es) $display("FAIL %s_diff got %0d want %0d", nm, s_o, es); else pass_cnt++;
        chk_cnt++; if (c_o !== ec) $display("FAIL %s_noborrow got %b want %b", nm, c_o, ec); else pass_cnt++;
        @(negedge clk);
    endtask
`endif

    // start held high: a new operation every W+2 cycles, sum 2 each time.
    task automatic test_back_to_back();
        int t = 0; int last_t = -1; int n_done = 0; int bad_gap = 0; int bad_sum = 0;
        @(negedge clk);
        a = 8'd1; b = 8'd1; start = 1'b1;
        for (int k = 0; k < 4 * (W + 2) + 3; k++) begin
            @(negedge clk); t++;
            if (done) begin
                n_done++;
                if (sum !== 8'd2) bad_sum++;
                if (last_t >= 0 && t - last_t !== W + 2) bad_gap++;
                last_t = t;
            end
        end
        start = 1'b0;
        chk_cnt++; if (n_done !== 4) $display("FAIL b2b_done_count got %0d want 4", n_done); else pass_cnt++;
        chk_cnt++; if (bad_gap !== 0) $display("FAIL b2b_period bad_gaps=%0d want 0", bad_gap); else pass_cnt++;
        chk_cnt++; if (bad_sum !== 0) $display("FAIL b2b_sum bad_sums=%0d want 0", bad_sum); else pass_cnt++;
        for (int k = 0; k < W + 3; k++) @(negedge clk);
    endtask

    // Extra start pulses while busy must not produce extra done strobes.
    task automatic test_ignore_start();
        int n_done = 0;
        @(negedge clk);
        a = 8'd10; b = 8'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3 * W; k++) begin
            start = (k == 2 || k == 5 || k == W) ? 1'b1 : 1'b0;
            if (done) n_done++;
            @(negedge clk);
            if (start && !busy && !done) start = 1'b0;
        end
        start = 1'b0;
        chk_cnt++; if (n_done !== 1) $display("FAIL ignore_start_done_count got %0d want 1", n_done); else pass_cnt++;
        chk_cnt++; if (sum !== 8'd30) $display("FAIL ignore_start_sum got %0d want 30", sum); else pass_cnt++;
        for (int k = 0; k < W + 3; k++) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int n_done = 0;
        @(negedge clk);
        a = 8'd200; b = 8'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_cnt++; if ({busy, done, sum, carry_out} !== '0) $display("FAIL midrst_outputs got busy=%b done=%b sum=%0d c=%b want all 0", busy, done, sum, carry_out); else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk_cnt++; if (n_done !== 0) $display("FAIL midrst_no_done got %0d want 0", n_done); else pass_cnt++;
        chk_cnt++; if (dbg_state !== 2'd0) $display("FAIL midrst_idle got %0d want 0", dbg_state); else pass_cnt++;
        test_add(8'd200, 8'd100, 8'd44, 1'b1, "after_rst");
    endtask

    initial begin
        test_reset();
        test_add(8'd3,   8'd5,  8'd8,   1'b0, "add_3_5");
        test_add(8'd255, 8'd1,  8'd0,   1'b1, "add_255_1");
        test_add(8'd170, 8'd85, 8'd255, 1'b0, "add_170_85");
        test_back_to_back();
        test_ignore_start();
        test_add(8'd170, 8'd85, 8'd255, 1'b0, "pre_rst");
        test_reset_mid_run();
`ifdef SERIAL_ADD_SUB_EN
        test_sub(8'd5, 8'd3, 8'd2,   1'b1, "sub_5_3");
        test_sub(8'd3, 8'd5, 8'd254, 1'b0, "sub_3_5");
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
